// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - accumulator command engine in front of the combinational ALU
//
// Purpose:
//   Accepts one command at a time, drives the ALU from the accumulator,
//   latched operand/opcode and carry flag, writes the ALU result back into
//   the accumulator, and returns the result with its flags.
//   Opcode 0 (LOAD) is handled locally; 1..15 go to the ALU.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_opcode          0 = LOAD, 1..15 = ALU operation
//   cmd_operand         B operand or load value
//   rsp_valid/ready     response handshake
//   rsp_data            result value (accumulator on a rejected opcode)
//   rsp_flags           {parity, borrow, zero, carry}
//   rsp_err             ALU rejected the opcode
//   acc_out             current accumulator
//   alu_a/b/carry_in/opcode   registered ALU operand side
//   alu_y, alu_carry_out, alu_zero, alu_borrow, alu_parity, alu_invalid_op
//                       ALU result side, sampled only in EXEC

module alu_cmd_sequencer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_opcode,
  input  logic [BUS_WIDTH-1:0] cmd_operand,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_data,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic [BUS_WIDTH-1:0] acc_out,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  output logic [3:0]           alu_opcode,
  input  logic [BUS_WIDTH-1:0] alu_y,
  input  logic                 alu_carry_out,
  input  logic                 alu_zero,
  input  logic                 alu_borrow,
  input  logic                 alu_parity,
  input  logic                 alu_invalid_op
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_LOAD = 4'd0;

  state_t               r_state;
  logic [BUS_WIDTH-1:0] r_acc;
  logic [BUS_WIDTH-1:0] r_operand;
  logic [3:0]           r_opcode;
  logic                 r_carry;
  logic                 r_borrow;
  logic                 r_zero;
  logic                 r_parity;
  logic [BUS_WIDTH-1:0] r_rsp_data;
  logic                 r_rsp_err;
  logic                 r_rsp_valid;
  logic                 r_cmd_ready;

  logic                 w_is_load;
  logic                 w_load_zero;
  logic                 w_load_parity;

  assign w_is_load     = (r_opcode == OP_LOAD);
  assign w_load_zero   = (r_operand == '0);
  assign w_load_parity = ^r_operand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_operand   <= '0;
      r_opcode    <= 4'd0;
      r_carry     <= 1'b0;
      r_borrow    <= 1'b0;
      r_zero      <= 1'b0;
      r_parity    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_opcode    <= cmd_opcode;
            r_operand   <= cmd_operand;
            r_cmd_ready <= 1'b0;
            r_state     <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (w_is_load) begin
            // ALU flags invalid_op for opcode 0; that is expected and ignored.
            r_acc      <= r_operand;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_zero     <= w_load_zero;
            r_parity   <= w_load_parity;
            r_rsp_data <= r_operand;
            r_rsp_err  <= 1'b0;
          end else if (alu_invalid_op) begin
            // Rejected opcode: machine state untouched, echo the accumulator.
            r_rsp_data <= r_acc;
            r_rsp_err  <= 1'b1;
          end else begin
            r_acc      <= alu_y;
            r_carry    <= alu_carry_out;
            r_borrow   <= alu_borrow;
            r_zero     <= alu_zero;
            r_parity   <= alu_parity;
            r_rsp_data <= alu_y;
            r_rsp_err  <= 1'b0;
          end
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end

        S_RESP: begin
          // Returning to IDLE rather than accepting here guarantees at least
          // one IDLE cycle between responses (no bypass path).
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_flags    = {r_parity, r_borrow, r_zero, r_carry};
  assign rsp_err      = r_rsp_err;
  assign acc_out      = r_acc;
  assign alu_a        = r_acc;
  assign alu_b        = r_operand;
  assign alu_carry_in = r_carry;
  assign alu_opcode   = r_opcode;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed bench for alu_cmd_sequencer with a behavioural ALU

module tb_alu_cmd_sequencer;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_opcode;
  logic [W-1:0] cmd_operand;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [W-1:0] acc_out;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_carry_in;
  logic [3:0]   alu_opcode;
  logic [W-1:0] alu_y;
  logic         alu_carry_out;
  logic         alu_zero;
  logic         alu_borrow;
  logic         alu_parity;
  logic         alu_invalid_op;

  int n_total;
  int n_pass;

  alu_cmd_sequencer #(.BUS_WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_opcode    (cmd_opcode),
    .cmd_operand   (cmd_operand),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_flags     (rsp_flags),
    .rsp_err       (rsp_err),
    .acc_out       (acc_out),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_carry_in  (alu_carry_in),
    .alu_opcode    (alu_opcode),
    .alu_y         (alu_y),
    .alu_carry_out (alu_carry_out),
    .alu_zero      (alu_zero),
    .alu_borrow    (alu_borrow),
    .alu_parity    (alu_parity),
    .alu_invalid_op(alu_invalid_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 1 ADD, 2 ADC, 3 SUB, 4 AND, 5 OR, 6 XOR, 8 ROL, 9 ROR; others invalid.
  logic [W:0] sum;
  always_comb begin
    sum            = '0;
    alu_y          = '0;
    alu_carry_out  = 1'b0;
    alu_borrow     = 1'b0;
    alu_invalid_op = 1'b0;
    case (alu_opcode)
      4'd1: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_y = sum[W-1:0]; alu_carry_out = sum[W]; end
      4'd2: begin sum = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_carry_in}; alu_y = sum[W-1:0]; alu_carry_out = sum[W]; end
      4'd3: begin alu_y = alu_a - alu_b; alu_borrow = (alu_a < alu_b); end
      4'd4: alu_y = alu_a & alu_b;
      4'd5: alu_y = alu_a | alu_b;
      4'd6: alu_y = alu_a ^ alu_b;
      4'd8: alu_y = {alu_a[W-2:0], alu_a[W-1]};
      4'd9: alu_y = {alu_a[0], alu_a[W-1:1]};
      default: alu_invalid_op = 1'b1;
    endcase
    alu_zero   = (alu_y == '0);
    alu_parity = ^alu_y;
  end

  // Present a command and return #1 after the edge that accepted it.
  task automatic send_cmd(input logic [3:0] op, input logic [W-1:0] opnd);
    bit done;
    done = 1'b0;
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_opcode  = op;
    cmd_operand = opnd;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL cmd_accept_timeout: cmd_ready never 1 for op %0d", op);
    end
  endtask

  // Wait (bounded) until rsp_valid, sampled #1 after an edge.
  task automatic wait_rsp(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL %s_rsp_timeout: rsp_valid never 1", tag);
    end
  endtask

  task automatic consume_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // Run one command to completion and check data/flags/err.
  task automatic run_check(input string tag, input logic [3:0] op, input logic [W-1:0] opnd,
                           input logic [W-1:0] exp_d, input logic [3:0] exp_f, input logic exp_e);
    send_cmd(op, opnd);
    wait_rsp(tag);
    n_total++;
    if (rsp_data !== exp_d || rsp_flags !== exp_f || rsp_err !== exp_e)
      $display("FAIL %s: got data=%h flags=%b err=%b want data=%h flags=%b err=%b",
               tag, rsp_data, rsp_flags, rsp_err, exp_d, exp_f, exp_e);
    else n_pass++;
    consume_rsp();
  endtask

  task automatic test_reset();
    run_check("reset_preload", 4'd0, 8'hA5, 8'hA5, 4'b0000, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || acc_out !== 8'h00 || rsp_data !== 8'h00 ||
        rsp_flags !== 4'b0000 || rsp_err !== 1'b0 || alu_b !== 8'h00 || alu_opcode !== 4'd0)
      $display("FAIL reset_async: got rdy=%b vld=%b acc=%h data=%h flags=%b err=%b b=%h op=%h want 1 0 00 00 0000 0 00 0",
               cmd_ready, rsp_valid, acc_out, rsp_data, rsp_flags, rsp_err, alu_b, alu_opcode);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || acc_out !== 8'h00)
      $display("FAIL reset_idle_stable: got rdy=%b vld=%b acc=%h want 1 0 00", cmd_ready, rsp_valid, acc_out);
    else n_pass++;
  endtask

  task automatic test_carry_chain();
    send_cmd(4'd0, 8'hF0);
    n_total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL latency_exec: got vld=%b rdy=%b want 0 0", rsp_valid, cmd_ready);
    else n_pass++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0)
      $display("FAIL latency_rsp: got vld=%b data=%h want 1 f0", rsp_valid, rsp_data);
    else n_pass++;
    consume_rsp();
    run_check("adc_carry_out", 4'd2, 8'h20, 8'h10, 4'b1001, 1'b0);
    run_check("adc_carry_in", 4'd2, 8'h00, 8'h11, 4'b0000, 1'b0);
    n_total++;
    if (acc_out !== 8'h11) $display("FAIL chain_acc: got %h want 11", acc_out);
    else n_pass++;
  endtask

  task automatic test_sub_rotate();
    run_check("load_05", 4'd0, 8'h05, 8'h05, 4'b0000, 1'b0);
    run_check("sub_borrow", 4'd3, 8'h07, 8'hFE, 4'b1100, 1'b0);
    run_check("load_81", 4'd0, 8'h81, 8'h81, 4'b0000, 1'b0);
    run_check("rol", 4'd8, 8'h00, 8'h03, 4'b0000, 1'b0);
    run_check("load_zero", 4'd0, 8'h00, 8'h00, 4'b0010, 1'b0);
    run_check("load_ff", 4'd0, 8'hFF, 8'hFF, 4'b0000, 1'b0);
    run_check("add_wrap", 4'd1, 8'h01, 8'h00, 4'b0011, 1'b0);
  endtask

  task automatic test_invalid();
    run_check("invalid_after_add", 4'd12, 8'h55, 8'h00, 4'b0011, 1'b1);
    run_check("load_3c", 4'd0, 8'h3C, 8'h3C, 4'b0000, 1'b0);
    run_check("invalid_after_load", 4'd12, 8'h77, 8'h3C, 4'b0000, 1'b1);
    n_total++;
    if (acc_out !== 8'h3C) $display("FAIL invalid_acc: got %h want 3c", acc_out);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit stable;
    send_cmd(4'd0, 8'h07);
    wait_rsp("bp");
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_opcode  = 4'd0;
    cmd_operand = 8'h99;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h07 || rsp_flags !== 4'b1000 || cmd_ready !== 1'b0) begin
        stable = 1'b0;
        $display("FAIL bp_hold_cycle%0d: got vld=%b data=%h flags=%b rdy=%b want 1 07 1000 0",
                 i, rsp_valid, rsp_data, rsp_flags, cmd_ready);
      end
    end
    n_total++;
    if (stable) n_pass++;
    consume_rsp();
    n_total++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || acc_out !== 8'h07)
      $display("FAIL bp_consumed: got vld=%b rdy=%b acc=%h want 0 1 07", rsp_valid, cmd_ready, acc_out);
    else n_pass++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_total++;
    if (cmd_ready !== 1'b0 || alu_b !== 8'h99)
      $display("FAIL bp_next_accept: got rdy=%b b=%h want 0 99", cmd_ready, alu_b);
    else n_pass++;
    wait_rsp("bp2");
    n_total++;
    if (rsp_data !== 8'h99 || rsp_flags !== 4'b0000)
      $display("FAIL bp_next_rsp: got data=%h flags=%b want 99 0000", rsp_data, rsp_flags);
    else n_pass++;
    consume_rsp();
  endtask

  task automatic check_no_rsp(input string tag);
    bit clean;
    clean = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) clean = 1'b0;
    end
    n_total++;
    if (!clean) $display("FAIL %s: got rsp_valid=1 after reset want 0", tag);
    else n_pass++;
  endtask

  task automatic test_midop_reset();
    run_check("midop_preload", 4'd0, 8'h11, 8'h11, 4'b0000, 1'b0);
    send_cmd(4'd0, 8'h42);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rsp_valid !== 1'b0 || acc_out !== 8'h00 || cmd_ready !== 1'b1)
      $display("FAIL reset_in_exec: got vld=%b acc=%h rdy=%b want 0 00 1", rsp_valid, acc_out, cmd_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    check_no_rsp("no_rsp_after_exec_reset");
    send_cmd(4'd0, 8'h42);
    wait_rsp("midop_resp");
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (rsp_valid !== 1'b0 || acc_out !== 8'h00)
      $display("FAIL reset_in_resp: got vld=%b acc=%h want 0 00", rsp_valid, acc_out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    check_no_rsp("no_rsp_after_resp_reset");
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_opcode  = 4'd0;
    cmd_operand = '0;
    rsp_ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_carry_chain();
    test_sub_rotate();
    test_invalid();
    test_backpressure();
    test_midop_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
